hc595_chain_driver: RTL and testbench

- Parallel-to-serial driver for a daisy-chained SN74HC595 output-expander string.
- Accepts one 8*N-bit word per transaction over a valid/ready handshake, then emits it MSB-first on sdo/sclk and pulses lock so all chips update their outputs together.
- Captures the bits returned on sdi from the end of the chain, which are the previous chain contents, for readback and integrity checking.
- Sits between the CNC output-register logic (upstream) and the 595 chain (downstream).

---
 rtl/hc595_chain_driver_if.sv | 22 ++
 rtl/hc595_chain_driver.sv | 159 +++++++++++++++
 tb/tb_hc595_chain_driver.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hc595_chain_driver_if.sv
// Upstream word/handshake bundle for hc595_chain_driver.
// The master side is the CNC output-register logic. The slave side is the chain driver.
interface hc595_chain_driver_if #(
   parameter int N = 6
);
   logic [8*N-1:0] din;
   logic           din_valid;
   logic           din_ready;
   logic [8*N-1:0] rdbk;
   logic           done;
   logic           err;

   modport master (
      output din, din_valid,
      input  din_ready, rdbk, done, err
   );

   modport slave (
      input  din, din_valid,
      output din_ready, rdbk, done, err
   );
endinterface

// File: rtl/hc595_chain_driver.sv
// Serial driver for a daisy-chained SN74HC595 string.
// Accepts one 8*N-bit word per handshake and shifts it out MSB-first on sclk/sdo.
// Pulses lock so that every chip updates its outputs at the same time.
// The bits returning on sdi are the previous chain contents. They are captured into rdbk.
// Optional macro HC595_READBACK_CHECK_EN enables the readback compare.
// With the macro, err flags a difference between the readback and the previously sent word.
// Without the macro, err is tied low. rdbk is captured in both builds.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | din_ready high, waiting for din_valid
//   S_LOW   | sclk low for CLK_DIV cycles, sdo presents the current MSB
//   S_HIGH  | sclk high for CLK_DIV cycles, shift out on exit
//   S_LATCH | lock high for LOCK_W cycles to update the storage registers
//   S_DONE  | one-cycle done pulse, rdbk/err updated
module hc595_chain_driver #(
   parameter int N       = 6,
   parameter int CLK_DIV = 4,
   parameter int LOCK_W  = 2
) (
   input  logic                  srclk,
   input  logic                  srclrn,
   hc595_chain_driver_if.slave   bus,
   output logic                  o_sclk,
   output logic                  o_sdo,
   output logic                  o_lock,
   input  logic                  i_sdi
);
   localparam int W  = 8 * N;
   localparam int CW = $clog2(W + 1);
   localparam logic [7:0]    DIV_LOAD  = 8'(CLK_DIV - 1);
   localparam logic [7:0]    LOCK_LOAD = 8'(LOCK_W - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(W - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_LATCH, S_DONE} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [7:0]    r_div;
   logic [CW-1:0] r_bitcnt;
   logic [W-1:0]  r_shreg;
   logic [W-1:0]  r_rdbk_sh;
   logic [W-1:0]  r_rdbk;
   logic          r_sclk;
   logic          r_lock;
   logic          r_done;
   logic          r_ready;
   logic          w_div_tc;
   logic          w_hs;
   logic          w_last_bit;

   assign w_div_tc   = (r_div == 8'd0);
   assign w_hs       = (r_state == S_IDLE) && bus.din_valid;
   assign w_last_bit = (r_bitcnt == BIT_LAST);

   // next-state decode; every phase ends on the divider terminal count
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_hs)     w_next = S_LOW;
         S_LOW:   if (w_div_tc) w_next = S_HIGH;
         S_HIGH:  if (w_div_tc) w_next = w_last_bit ? S_LATCH : S_LOW;
         S_LATCH: if (w_div_tc) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge srclk or negedge srclrn) begin
      if (!srclrn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // divider reload/countdown, shift register, bit counter and sdi capture
   always_ff @(posedge srclk or negedge srclrn) begin
      if (!srclrn) begin
         r_div     <= '0;
         r_bitcnt  <= '0;
         r_shreg   <= '0;
         r_rdbk_sh <= '0;
      end else begin
         if (w_next != r_state) begin
            case (w_next)
               S_LOW, S_HIGH: r_div <= DIV_LOAD;
               S_LATCH:       r_div <= LOCK_LOAD;
               default:       r_div <= '0;
            endcase
         end else if (!w_div_tc) begin
            r_div <= r_div - 8'd1;
         end
         if (w_hs) begin
            r_shreg  <= bus.din;
            r_bitcnt <= '0;
         end
         // sdi is sampled just before the rising sclk edge that moves the chain
         if (r_state == S_LOW && w_div_tc)
            r_rdbk_sh <= {r_rdbk_sh[W-2:0], i_sdi};
         if (r_state == S_HIGH && w_div_tc) begin
            r_shreg  <= {r_shreg[W-2:0], 1'b0};
            r_bitcnt <= r_bitcnt + CW'(1);
         end
      end
   end

   // registered pin/handshake outputs decoded from the next state, glitch-free on the chain
   always_ff @(posedge srclk or negedge srclrn) begin
      if (!srclrn) begin
         r_sclk  <= 1'b0;
         r_lock  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_sclk  <= (w_next == S_HIGH);
         r_lock  <= (w_next == S_LATCH);
         r_done  <= (w_next == S_DONE);
         r_ready <= (w_next == S_IDLE);
      end
   end

   // readback word becomes visible together with done
   always_ff @(posedge srclk or negedge srclrn) begin
      if (!srclrn)                                    r_rdbk <= '0;
      else if (w_next == S_DONE && r_state != S_DONE) r_rdbk <= r_rdbk_sh;
   end

`ifdef HC595_READBACK_CHECK_EN
   logic [W-1:0] r_word;
   logic [W-1:0] r_prev;
   logic         r_err;

   // compare readback with what the previous transaction loaded into the chain
   always_ff @(posedge srclk or negedge srclrn) begin
      if (!srclrn) begin
         r_word <= '0;
         r_prev <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_hs) r_word <= bus.din;
         if (w_next == S_DONE && r_state != S_DONE) begin
            r_err  <= (r_rdbk_sh != r_prev);
            r_prev <= r_word;
         end
      end
   end

   assign bus.err = r_err;
`else
   assign bus.err = 1'b0;
`endif

   // the shift register MSB drives sdo directly; it is zero whenever idle
   assign o_sdo         = r_shreg[W-1];
   assign o_sclk        = r_sclk;
   assign o_lock        = r_lock;
   assign bus.din_ready = r_ready;
   assign bus.done      = r_done;
   assign bus.rdbk      = r_rdbk;
endmodule

// File: tb/tb_hc595_chain_driver.sv
// Bench for hc595_chain_driver with a behavioural SN74HC595 chain looped back on sdi.
// A transaction-level model predicts every output on every cycle from the handshake time and word.
module tb_hc595_chain_driver;
   localparam int N         = 6;
   localparam int CLK_DIV   = 2;
   localparam int LOCK_W    = 2;
   localparam int W         = 8 * N;
   localparam int SHIFT_CYC = W * 2 * CLK_DIV;
   localparam int LAT       = 1 + SHIFT_CYC + LOCK_W;
`ifdef HC595_READBACK_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic srclk  = 1'b0;
   logic srclrn = 1'b0;
   logic sclk, sdo, lock, sdi;
   bit   stuck = 1'b0;

   hc595_chain_driver_if #(.N(N)) bus ();

   hc595_chain_driver #(.N(N), .CLK_DIV(CLK_DIV), .LOCK_W(LOCK_W)) dut (
      .srclk  (srclk),
      .srclrn (srclrn),
      .bus    (bus),
      .o_sclk (sclk),
      .o_sdo  (sdo),
      .o_lock (lock),
      .i_sdi  (sdi)
   );

   always #5 srclk = ~srclk;

   // 595 chain: the shift register clears with srclrn, storage updates on lock
   logic [W-1:0] ch_sh = '0;
   logic [W-1:0] ch_q  = '0;
   int           lock_pulses = 0;
   always @(posedge sclk or negedge srclrn)
      if (!srclrn) ch_sh <= '0;
      else         ch_sh <= {ch_sh[W-2:0], sdo};
   always @(posedge lock) begin
      ch_q <= ch_sh;
      lock_pulses++;
   end
   assign sdi = stuck ? 1'b0 : ch_sh[W-1];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // transaction model: m_n counts srclk edges since the handshake edge
   bit           m_busy = 1'b0;
   int           m_n    = 0;
   logic [W-1:0] m_word = '0;
   logic [W-1:0] m_prev = '0;
   logic [W-1:0] m_rdbk = '0;
   bit           m_err  = 1'b0;
   bit           m_stk  = 1'b0;
   always @(posedge srclk or negedge srclrn) begin
      if (!srclrn) begin
         m_busy = 1'b0; m_n = 0; m_prev = '0; m_rdbk = '0; m_err = 1'b0;
      end else if (!m_busy) begin
         if (bus.din_valid) begin
            m_busy = 1'b1; m_n = 0; m_word = bus.din; m_stk = stuck;
         end
      end else begin
         m_n++;
         if (m_n == LAT - 1) begin
            m_rdbk = m_stk ? '0 : m_prev;
            m_err  = ERR_EN && (m_rdbk != m_prev);
            m_prev = m_word;
         end
         if (m_n == LAT) m_busy = 1'b0;
      end
   end

   // per-cycle compare against the model, plus sclk edge and busy-length accounting
   int rises = 0;
   int run   = 0;
   bit prev_sclk = 1'b0;
   always @(negedge srclk) begin
      bit e_ready, e_sclk, e_sdo, e_lock, e_done;
      if (!srclrn) begin
         rises = 0; run = 0; prev_sclk = 1'b0;
      end else begin
         e_ready = !m_busy; e_sclk = 1'b0; e_sdo = 1'b0; e_lock = 1'b0; e_done = 1'b0;
         if (m_busy) begin
            if (m_n < SHIFT_CYC) begin
               e_sclk = (m_n % (2 * CLK_DIV)) >= CLK_DIV;
               e_sdo  = m_word[W - 1 - m_n / (2 * CLK_DIV)];
            end else if (m_n < SHIFT_CYC + LOCK_W) e_lock = 1'b1;
            else                                   e_done = 1'b1;
         end
         chk("din_ready", bus.din_ready, e_ready);
         chk("sclk", sclk, e_sclk);
         chk("sdo", sdo, e_sdo);
         chk("lock", lock, e_lock);
         chk("done", bus.done, e_done);
         chk("rdbk", bus.rdbk, m_rdbk);
         chk("err", bus.err, m_err);
         if (sclk && !prev_sclk) rises++;
         prev_sclk = sclk;
         if (e_done) begin
            chk("sclk_rises", rises, W);
            rises = 0;
         end
         if (!bus.din_ready) run++;
         else if (run != 0) begin
            chk("ready_low_cycles", run, LAT);
            run = 0;
         end
      end
   end

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] w;
      w = {16'($urandom), $urandom};
      return w;
   endfunction

   task automatic handshake(input logic [W-1:0] w);
      @(negedge srclk);
      while (m_busy) @(negedge srclk);
      bus.din = w; bus.din_valid = 1'b1;
      @(posedge srclk); #1;
   endtask

   task automatic finish_txn(input logic [W-1:0] w, input bit noise, input bit hold,
                             input logic [W-1:0] hold_w);
      int lat = 0;
      do begin
         @(negedge srclk);
         lat++;
         if (hold) begin
            bus.din = hold_w; bus.din_valid = 1'b1;
         end else if (noise && lat < 150) begin
            bus.din = rnd_word(); bus.din_valid = 1'b1;
         end else begin
            bus.din_valid = 1'b0;
         end
      end while (!bus.done && lat < 400);
      chk("done_latency", lat, LAT);
      chk("chain_q", ch_q, w);
   endtask

   task automatic send(input logic [W-1:0] w, input bit noise);
      handshake(w);
      finish_txn(w, noise, 1'b0, '0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, bus.din_ready, 1'b1);
      chk({tag, "_sclk"},  sclk, 1'b0);
      chk({tag, "_sdo"},   sdo, 1'b0);
      chk({tag, "_lock"},  lock, 1'b0);
      chk({tag, "_done"},  bus.done, 1'b0);
      chk({tag, "_rdbk"},  bus.rdbk, '0);
      chk({tag, "_err"},   bus.err, 1'b0);
   endtask

   initial begin
      logic [W-1:0] w, q_before;
      int k, lp_before;
      bus.din = '0; bus.din_valid = 1'b0;
      #12;
      chk_reset_vals("reset");
      @(negedge srclk); srclrn = 1'b1;
      repeat (2) @(negedge srclk);

      send(48'hA5_3C_0F_F0_81_7E, 1'b0);
      chk("first_rdbk", bus.rdbk, 48'h0);
      chk("first_err", bus.err, 1'b0);
      chk("first_q", ch_q, 48'hA5_3C_0F_F0_81_7E);

      handshake(48'h1234_5678_9ABC);
      finish_txn(48'h1234_5678_9ABC, 1'b0, 1'b1, 48'hFFFF_0000_FFFF);
      @(posedge srclk); @(posedge srclk); #1;
      finish_txn(48'hFFFF_0000_FFFF, 1'b0, 1'b0, '0);
      chk("b2b_rdbk", bus.rdbk, 48'h1234_5678_9ABC);
      chk("b2b_err", bus.err, 1'b0);

      send(48'hC3C3_5A5A_0001, 1'b1);
      chk("busy_rdbk", bus.rdbk, 48'hFFFF_0000_FFFF);

      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge srclk);
         send(rnd_word(), 1'($urandom_range(0, 1)));
      end

      w = rnd_word() | 48'h1;
      handshake(w);
      bus.din_valid = 1'b0;
      q_before  = ch_q;
      lp_before = lock_pulses;
      k = 0;
      while (rises < 20 && k < 500) begin
         @(negedge srclk);
         k++;
      end
      chk("mid_rises_reached", rises, 20);
      #3 srclrn = 1'b0;
      #1 chk_reset_vals("abort");
      repeat (3) @(negedge srclk);
      srclrn = 1'b1;
      repeat (SHIFT_CYC) @(negedge srclk);
      chk("abort_no_lock", lock_pulses, lp_before);
      chk("abort_q_kept", ch_q, q_before);

      send(48'h0F0F_0F0F_0F0F, 1'b0);
      chk("post_abort_rdbk", bus.rdbk, 48'h0);
      chk("post_abort_err", bus.err, 1'b0);

      stuck = 1'b1;
      send(48'h8000_0000_0003, 1'b0);
      chk("stuck_rdbk", bus.rdbk, 48'h0);
      chk("stuck_err", bus.err, ERR_EN);
      @(negedge srclk); stuck = 1'b0;
      send(48'h7E7E_1111_2222, 1'b0);
      chk("clean_rdbk", bus.rdbk, 48'h8000_0000_0003);
      chk("clean_err", bus.err, 1'b0);

      repeat (4) @(negedge srclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
